// File: rtl/uart_boot_loader.sv
// uart_boot_loader: receives a word count and a little-endian byte stream from
// a UART receiver, assembles 32-bit words and writes them to consecutive
// memory addresses from 0 while holding the MIPS core stalled.
//
// Ports:
//   clk, reset            clock (rising edge), asynchronous active-high reset
//   start                 pulse that begins a load session (ignored while busy)
//   rx_valid, rx_data     received byte strobe and data
//   mem_we                one-cycle write strobe per assembled word
//   mem_addr, mem_wdata   word address and data for the write
//   core_hold             1 except while DONE
//   busy, done, error     session status levels
//
// Optional feature: define BOOT_TIMEOUT_EN to abort a session to ERROR when no
// byte arrives for TIMEOUT_CYCLES clocks in GET_COUNT or GET_BYTES.
module uart_boot_loader #(
    parameter int unsigned DATA_WIDTH     = 32,
    parameter int unsigned ADDR_WIDTH     = 8,
    parameter int unsigned TIMEOUT_CYCLES = 50000000
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic                  rx_valid,
    input  logic [7:0]            rx_data,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    output logic                  core_hold,
    output logic                  busy,
    output logic                  done,
    output logic                  error
);

    localparam logic [2:0] S_IDLE      = 3'd0;
    localparam logic [2:0] S_GET_COUNT = 3'd1;
    localparam logic [2:0] S_GET_BYTES = 3'd2;
    localparam logic [2:0] S_WRITE     = 3'd3;
    localparam logic [2:0] S_DONE      = 3'd4;
    localparam logic [2:0] S_ERROR     = 3'd5;

    // Elaboration-time parameter sanity checks.
    if (DATA_WIDTH != 32) begin : g_bad_data_width
        $error("uart_boot_loader: DATA_WIDTH must be 32");
    end
    if (TIMEOUT_CYCLES == 0) begin : g_bad_timeout
        $error("uart_boot_loader: TIMEOUT_CYCLES must be non-zero");
    end

    logic [2:0]            state_q, state_d;
    logic [7:0]            count_q, count_d;
    logic [1:0]            idx_q, idx_d;
    logic [DATA_WIDTH-1:0] word_q, word_d;
    logic                  mem_we_q, mem_we_d;
    logic [ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;
    logic [DATA_WIDTH-1:0] mem_wdata_q, mem_wdata_d;
    logic                  core_hold_q, core_hold_d;
    logic                  busy_q, busy_d;
    logic                  done_q, done_d;
    logic                  error_q, error_d;
    logic                  tmo_hit_c;

`ifdef BOOT_TIMEOUT_EN
    localparam int unsigned TMO_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [TMO_W-1:0] tmo_q, tmo_d;

    // Inter-byte counter: runs only while waiting in the same receive state
    // with no byte; entry, any byte and WRITE all clear it.
    always_comb begin
        tmo_d = '0;
        if ((state_q == S_GET_COUNT || state_q == S_GET_BYTES) &&
            state_d == state_q && !rx_valid) begin
            tmo_d = tmo_q + TMO_W'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) tmo_q <= '0;
        else       tmo_q <= tmo_d;
    end

    // Fires on the cycle the counter has seen TIMEOUT_CYCLES-1 idle clocks,
    // so ERROR is entered TIMEOUT_CYCLES clocks after the last byte.
    assign tmo_hit_c = (tmo_q == TMO_W'(TIMEOUT_CYCLES - 1));
`else
    assign tmo_hit_c = 1'b0;
`endif

    // Next-state, datapath and registered-output decode.
    always_comb begin
        state_d     = state_q;
        count_d     = count_q;
        idx_d       = idx_q;
        word_d      = word_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;

        case (state_q)
            S_IDLE, S_DONE, S_ERROR: begin
                if (start) begin
                    state_d    = S_GET_COUNT;
                    idx_d      = 2'd0;
                    mem_addr_d = '0;
                end
            end
            S_GET_COUNT: begin
                if (rx_valid) begin
                    count_d = rx_data;
                    idx_d   = 2'd0;
                    state_d = (rx_data == 8'd0) ? S_ERROR : S_GET_BYTES;
                end else if (tmo_hit_c) begin
                    state_d = S_ERROR;
                end
            end
            S_GET_BYTES: begin
                if (rx_valid) begin
                    word_d[{idx_q, 3'b000} +: 8] = rx_data;
                    idx_d = idx_q + 2'd1;
                    if (idx_q == 2'd3) begin
                        state_d     = S_WRITE;
                        mem_wdata_d = {rx_data, word_q[23:0]};
                    end
                end else if (tmo_hit_c) begin
                    state_d = S_ERROR;
                end
            end
            S_WRITE: begin
                mem_addr_d = mem_addr_q + ADDR_WIDTH'(1);
                count_d    = count_q - 8'd1;
                if (count_q == 8'd1) begin
                    state_d = S_DONE;
                end else begin
                    state_d = S_GET_BYTES;
                    // A byte arriving during the write starts the next word.
                    if (rx_valid) begin
                        word_d[7:0] = rx_data;
                        idx_d       = 2'd1;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase

        mem_we_d    = (state_d == S_WRITE);
        busy_d      = (state_d == S_GET_COUNT) || (state_d == S_GET_BYTES) ||
                      (state_d == S_WRITE);
        done_d      = (state_d == S_DONE);
        error_d     = (state_d == S_ERROR);
        core_hold_d = (state_d != S_DONE);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= S_IDLE;
            count_q     <= '0;
            idx_q       <= '0;
            word_q      <= '0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            core_hold_q <= 1'b1;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            error_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            count_q     <= count_d;
            idx_q       <= idx_d;
            word_q      <= word_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            core_hold_q <= core_hold_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            error_q     <= error_d;
        end
    end

    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign core_hold = core_hold_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign error     = error_q;

endmodule

// File: tb/tb_uart_boot_loader.sv
// Directed bench for uart_boot_loader: inputs driven on the falling edge,
// outputs sampled on the falling edge after the capturing rising edge.
module tb_uart_boot_loader;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic        rx_valid;
    logic [7:0]  rx_data;
    logic        mem_we;
    logic [7:0]  mem_addr;
    logic [31:0] mem_wdata;
    logic        core_hold;
    logic        busy;
    logic        done;
    logic        error;

    int checks = 0;
    int errors = 0;
    int we_cnt = 0;

    uart_boot_loader #(
        .DATA_WIDTH    (32),
        .ADDR_WIDTH    (8),
        .TIMEOUT_CYCLES(100)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .rx_valid (rx_valid),
        .rx_data  (rx_data),
        .mem_we   (mem_we),
        .mem_addr (mem_addr),
        .mem_wdata(mem_wdata),
        .core_hold(core_hold),
        .busy     (busy),
        .done     (done),
        .error    (error)
    );

    always #5 clk = ~clk;

    always @(negedge clk) if (mem_we === 1'b1) we_cnt++;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Drive a byte for one cycle starting now (at a falling edge).
    task automatic drive_byte(input logic [7:0] b);
        rx_valid = 1'b1;
        rx_data  = b;
        @(negedge clk);
        rx_valid = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b);
        @(negedge clk);
        drive_byte(b);
    endtask

    task automatic pulse_start;
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_we"},    32'(mem_we),    32'd0);
        check({tag, "_addr"},  32'(mem_addr),  32'd0);
        check({tag, "_wdata"}, mem_wdata,      32'd0);
        check({tag, "_hold"},  32'(core_hold), 32'd1);
        check({tag, "_busy"},  32'(busy),      32'd0);
        check({tag, "_done"},  32'(done),      32'd0);
        check({tag, "_err"},   32'(error),     32'd0);
    endtask

    // Sends the last byte of a word and checks the write in the following cycle.
    task automatic send_last(input string tag, input logic [7:0] b,
                             input logic [7:0] exp_addr, input logic [31:0] exp_data);
        send_byte(b);
        check({tag, "_we"},   32'(mem_we),   32'd1);
        check({tag, "_addr"}, 32'(mem_addr), 32'(exp_addr));
        check({tag, "_data"}, mem_wdata,     exp_data);
    endtask

    task automatic check_done(input string tag);
        check({tag, "_done"}, 32'(done),      32'd1);
        check({tag, "_hold"}, 32'(core_hold), 32'd0);
        check({tag, "_busy"}, 32'(busy),      32'd0);
        check({tag, "_err"},  32'(error),     32'd0);
    endtask

    initial begin
        reset    = 1'b1;
        start    = 1'b0;
        rx_valid = 1'b0;
        rx_data  = 8'h00;
        repeat (3) @(negedge clk);
        check_reset_outputs("rst");
        reset = 1'b0;

        // Two-word session.
        pulse_start();
        check("s1_busy", 32'(busy), 32'd1);
        check("s1_hold", 32'(core_hold), 32'd1);
        send_byte(8'h02);
        send_byte(8'h78);
        send_byte(8'h56);
        send_byte(8'h34);
        check("s1_nowe", 32'(mem_we), 32'd0);
        send_last("s1_w0", 8'h12, 8'd0, 32'h12345678);
        @(negedge clk);
        check("s1_we_drop", 32'(mem_we), 32'd0);
        check("s1_hold_data", mem_wdata, 32'h12345678);
        drive_byte(8'hEF);
        send_byte(8'hBE);
        send_byte(8'hAD);
        send_last("s1_w1", 8'hDE, 8'd1, 32'hDEADBEEF);
        @(negedge clk);
        check_done("s1");
        check("s1_wecnt", 32'(we_cnt), 32'd2);
        send_byte(8'h55);
        check("s1_ign_rx", 32'(busy), 32'd0);

        // Zero count aborts; then a valid session recovers.
        pulse_start();
        check("s2_done_clr", 32'(done), 32'd0);
        send_byte(8'h00);
        check("s2_err", 32'(error), 32'd1);
        check("s2_hold", 32'(core_hold), 32'd1);
        check("s2_busy", 32'(busy), 32'd0);
        check("s2_wecnt", 32'(we_cnt), 32'd2);
        pulse_start();
        check("s2_err_clr", 32'(error), 32'd0);
        send_byte(8'h01);
        send_byte(8'h01);
        send_byte(8'h02);
        send_byte(8'h03);
        send_last("s2_w0", 8'h04, 8'd0, 32'h04030201);
        @(negedge clk);
        check_done("s2");

        // Byte arriving in the WRITE cycle starts the next word.
        pulse_start();
        send_byte(8'h02);
        send_byte(8'hAA);
        send_byte(8'hBB);
        send_byte(8'hCC);
        send_last("s3_w0", 8'hDD, 8'd0, 32'hDDCCBBAA);
        drive_byte(8'h11);
        send_byte(8'h22);
        send_byte(8'h33);
        send_last("s3_w1", 8'h44, 8'd1, 32'h44332211);
        @(negedge clk);
        check_done("s3");

        // Extra start pulses mid-session are ignored.
        pulse_start();
        send_byte(8'h01);
        send_byte(8'h10);
        pulse_start();
        check("s4_busy", 32'(busy), 32'd1);
        send_byte(8'h20);
        send_byte(8'h30);
        pulse_start();
        send_last("s4_w0", 8'h40, 8'd0, 32'h40302010);
        @(negedge clk);
        check_done("s4");

        // Asynchronous reset mid-word, then a fresh session from address 0.
        pulse_start();
        send_byte(8'h02);
        send_byte(8'h01);
        send_byte(8'h02);
        #2 reset = 1'b1;
        #1 check_reset_outputs("s5_rst");
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check_reset_outputs("s5_idle");
        pulse_start();
        send_byte(8'h01);
        send_byte(8'h05);
        send_byte(8'h06);
        send_byte(8'h07);
        send_last("s5_w0", 8'h08, 8'd0, 32'h08070605);
        @(negedge clk);
        check_done("s5");

        // Silence after one byte.
        pulse_start();
        send_byte(8'h01);
        send_byte(8'h99);
`ifdef BOOT_TIMEOUT_EN
        repeat (99) @(negedge clk);
        check("s6_err_early", 32'(error), 32'd0);
        @(negedge clk);
        check("s6_err", 32'(error), 32'd1);
        check("s6_busy", 32'(busy), 32'd0);
`else
        repeat (150) @(negedge clk);
        check("s6_busy", 32'(busy), 32'd1);
        check("s6_err", 32'(error), 32'd0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/uart_boot_loader.md
UART_BOOT_LOADER -- requirements
Module: uart_boot_loader

Interface
REQ-001 Parameter DATA_WIDTH, default 32, memory word width; SHALL be fixed at 32 (four bytes per word).
REQ-002 Parameter ADDR_WIDTH, default 8, memory address width.
REQ-003 Parameter TIMEOUT_CYCLES, default 50000000, inter-byte timeout in clk cycles (1 s at 50 MHz); used only under BOOT_TIMEOUT_EN.
REQ-004 clk  input  1  system clock, rising edge; the block has one clock.
REQ-005 reset  input  1  asynchronous, active-high reset.
REQ-006 start  input  1  single-cycle pulse requesting a load session.
REQ-007 rx_valid  input  1  single-cycle pulse from the UART receiver marking a byte (Rx_flag).
REQ-008 rx_data  input  8  received byte, valid when rx_valid=1.
REQ-009 mem_we  output  1  instruction/data memory write strobe, one cycle per word.
REQ-010 mem_addr  output  ADDR_WIDTH  word address for the write.
REQ-011 mem_wdata  output  DATA_WIDTH  assembled word.
REQ-012 core_hold  output  1  holds the MIPS core stalled while 1.
REQ-013 busy  output  1  session in progress.
REQ-014 done  output  1  level, last session completed successfully.
REQ-015 error  output  1  level, last session aborted.

Function
REQ-016 SHALL implement states IDLE, GET_COUNT, GET_BYTES, WRITE, DONE, ERROR.
REQ-017 IDLE, DONE, ERROR: start=1 -> GET_COUNT next cycle, clearing done, error, the byte index and mem_addr (to 0).
REQ-018 GET_COUNT: rx_valid latches rx_data as word count N; N=0 -> ERROR; otherwise -> GET_BYTES.
REQ-019 GET_BYTES: each rx_valid stores a byte little-endian (first byte -> bits 7:0, fourth -> bits 31:24); the fourth byte -> WRITE.
REQ-020 WRITE lasts exactly one cycle: mem_we=1 with mem_wdata = the assembled word and mem_addr = the current word index; write occurs the cycle after the fourth byte's rx_valid.
REQ-021 Leaving WRITE: mem_addr increments modulo 2^ADDR_WIDTH; the remaining count decrements; count 0 -> DONE, else -> GET_BYTES.
REQ-022 rx_valid during WRITE SHALL be captured as byte 0 of the next word, with no loss; in DONE/ERROR/IDLE rx_valid SHALL be ignored.
REQ-023 start while busy (GET_COUNT, GET_BYTES, WRITE) SHALL be ignored.
REQ-024 mem_we SHALL be 0 in every state except WRITE; mem_addr/mem_wdata SHALL hold their values outside WRITE.
REQ-025 busy=1 in GET_COUNT, GET_BYTES and WRITE; done=1 only in DONE; error=1 only in ERROR.
REQ-026 core_hold=1 in every state except DONE; core_hold SHALL deassert in the first DONE cycle.

Reset
REQ-027 reset=1 SHALL force IDLE asynchronously, at any time including mid-session: mem_we=0, mem_addr=0, mem_wdata=0, core_hold=1, busy=0, done=0, error=0; the count, byte index and timeout counter are cleared.
REQ-028 A partly written memory image after mid-session reset SHALL NOT be flagged; recovery requires a new start.

Configuration
REQ-029 Macro BOOT_TIMEOUT_EN defined: in GET_COUNT and GET_BYTES a counter, cleared on entry and on every rx_valid, SHALL reach TIMEOUT_CYCLES -> ERROR on the next cycle; it is paused and cleared in WRITE.
REQ-030 BOOT_TIMEOUT_EN undefined: no counter logic; GET_COUNT/GET_BYTES wait indefinitely; TIMEOUT_CYCLES unused.

Verification
REQ-031 Reset, then start, then bytes 02,78,56,34,12,EF,BE,AD,DE -> writes 0x12345678 at addr 0 and 0xDEADBEEF at addr 1, each mem_we one cycle after its fourth byte; then done=1, core_hold=0.
REQ-032 start, then byte 00 -> error=1, no mem_we, core_hold=1; a second start with a valid session -> done=1.
REQ-033 Fourth byte followed by a rx_valid in the WRITE cycle -> the word is written and the extra byte appears as bits 7:0 of the next word.
REQ-034 reset pulse after 2 of 4 bytes -> all outputs at reset values immediately; a new session starts from addr 0.
REQ-035 BOOT_TIMEOUT_EN, TIMEOUT_CYCLES=100: start, count 01, one byte, then silence -> error=1 100 cycles after the last rx_valid; without the macro -> busy stays 1.
REQ-036 Extra start pulses during GET_BYTES -> no effect; the session completes normally.
